// File: rtl/lsu_dc_fill_ctl.sv
// lsu_dc_fill_ctl -- D-cache line-fill sequencer.
//
// Accepts one miss at a time and issues a single line read on the bus. Each
// returned 64-bit beat is written into the victim way with per-halfword even
// parity. The tag/valid is written only if no beat reported an error and the
// bus last-beat flag matched the beat count. The critical word is forwarded
// to the LSU in the data-write cycle of the beat that holds it.
//
// Optional feature: define RV_DC_FILL_WRAP_EN for a wrapped fill, where the
// critical beat is requested and returned first.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   miss_valid/ready/addr/way        miss request; word address, one-hot way
//   rd_req_valid/ready/addr          bus line-read request (byte address)
//   rd_rsp_valid/data/last/err       bus beat return (always consumed)
//   dc_rw_addr, dc_wr_en, dc_wr_data data-array write (word address, parity)
//   dc_rw_tag_addr, lsu_dc_tag_wren,
//   dc_tag_valid                     tag-array write
//   crit_valid, crit_data            critical-word forward
//   fill_done, fill_err, busy        completion pulses and busy status
module lsu_dc_fill_ctl #(
  parameter int unsigned NUM_WAYS   = 4,
  parameter int unsigned LINE_BEATS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_valid,
  output logic                miss_ready,
  input  logic [29:0]         miss_addr,
  input  logic [NUM_WAYS-1:0] miss_way,
  output logic                rd_req_valid,
  input  logic                rd_req_ready,
  output logic [31:0]         rd_req_addr,
  input  logic                rd_rsp_valid,
  input  logic [63:0]         rd_rsp_data,
  input  logic                rd_rsp_last,
  input  logic                rd_rsp_err,
  output logic [29:0]         dc_rw_addr,
  output logic [NUM_WAYS-1:0] dc_wr_en,
  output logic [67:0]         dc_wr_data,
  output logic [29:0]         dc_rw_tag_addr,
  output logic [NUM_WAYS-1:0] lsu_dc_tag_wren,
  output logic [NUM_WAYS-1:0] dc_tag_valid,
  output logic                crit_valid,
  output logic [31:0]         crit_data,
  output logic                fill_done,
  output logic                fill_err,
  output logic                busy
);

  localparam int unsigned   CW       = $clog2(LINE_BEATS);
  localparam int unsigned   OB       = CW + 3;
  localparam logic [CW-1:0] LAST_CNT = CW'(LINE_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_FLUSH,
    S_TAG
  } state_e;

  state_e              state_q, state_d;
  logic [29:0]         addr_q, addr_d;
  logic [NUM_WAYS-1:0] way_q, way_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                pipe_vld_q, pipe_vld_d;
  logic [CW-1:0]       pipe_idx_q, pipe_idx_d;
  logic [63:0]         pipe_data_q, pipe_data_d;

  logic [31-OB:0]      line_tag;
  logic [CW-1:0]       crit_idx;
  logic [CW-1:0]       beat_idx;
  logic [31:0]         req_addr;

  assign line_tag = addr_q[29:OB-2];
  assign crit_idx = addr_q[OB-3:1];

`ifdef RV_DC_FILL_WRAP_EN
  // Critical beat first; the index wraps naturally in CW bits.
  assign beat_idx = crit_idx + cnt_q;
  assign req_addr = {addr_q[29:1], 3'b000};
`else
  assign beat_idx = cnt_q;
  assign req_addr = {line_tag, {OB{1'b0}}};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      way_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      pipe_vld_q  <= 1'b0;
      pipe_idx_q  <= '0;
      pipe_data_q <= '0;
    end else begin
      addr_q      <= addr_d;
      way_q       <= way_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_idx_q  <= pipe_idx_d;
      pipe_data_q <= pipe_data_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    way_d       = way_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    pipe_vld_d  = 1'b0;
    pipe_idx_d  = pipe_idx_q;
    pipe_data_d = pipe_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (miss_valid) begin
          addr_d  = miss_addr;
          way_d   = miss_way;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (rd_req_ready) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (rd_rsp_valid) begin
          pipe_vld_d  = 1'b1;
          pipe_idx_d  = beat_idx;
          pipe_data_d = rd_rsp_data;
          cnt_d       = cnt_q + CW'(1);
          // A misplaced or missing last flag poisons the fill like a bus error.
          err_d       = err_q | rd_rsp_err | (rd_rsp_last != (cnt_q == LAST_CNT));
          if (cnt_q == LAST_CNT) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        state_d = err_q ? S_IDLE : S_TAG;
      end
      S_TAG: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs; everything is held low while rst is asserted.
  always_comb begin
    miss_ready      = 1'b0;
    rd_req_valid    = 1'b0;
    rd_req_addr     = '0;
    dc_rw_addr      = '0;
    dc_wr_en        = '0;
    dc_wr_data      = '0;
    dc_rw_tag_addr  = '0;
    lsu_dc_tag_wren = '0;
    dc_tag_valid    = '0;
    crit_valid      = 1'b0;
    crit_data       = '0;
    fill_done       = 1'b0;
    fill_err        = 1'b0;
    busy            = 1'b0;
    if (!rst) begin
      busy       = (state_q != S_IDLE);
      miss_ready = (state_q == S_IDLE);
      if (state_q == S_REQ) begin
        rd_req_valid = 1'b1;
        rd_req_addr  = req_addr;
      end
      // Beat captured last cycle is written now (covers FILL and FLUSH).
      if (pipe_vld_q) begin
        dc_wr_en   = way_q;
        dc_rw_addr = {line_tag, pipe_idx_q, 1'b0};
        dc_wr_data = {^pipe_data_q[63:48], ^pipe_data_q[47:32], pipe_data_q[63:32],
                      ^pipe_data_q[31:16], ^pipe_data_q[15:0],  pipe_data_q[31:0]};
        if (pipe_idx_q == crit_idx) begin
          crit_valid = 1'b1;
          crit_data  = addr_q[0] ? pipe_data_q[63:32] : pipe_data_q[31:0];
        end
      end
      if (state_q == S_FLUSH && err_q) begin
        fill_err = 1'b1;
      end
      if (state_q == S_TAG) begin
        lsu_dc_tag_wren = way_q;
        dc_tag_valid    = way_q;
        dc_rw_tag_addr  = {line_tag, {(OB-2){1'b0}}};
        fill_done       = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dc_fill_ctl.sv
// tb_lsu_dc_fill_ctl -- bench for the D-cache line-fill sequencer.
// Drives directed and randomized fills; expectations come from a
// transaction-level model using byte-address arithmetic.
module tb_lsu_dc_fill_ctl;
  localparam int unsigned NW         = 4;
  localparam int unsigned LB         = 4;
  localparam int unsigned LINE_BYTES = LB * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_valid;
  logic          miss_ready;
  logic [29:0]   miss_addr;
  logic [NW-1:0] miss_way;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [31:0]   rd_req_addr;
  logic          rd_rsp_valid;
  logic [63:0]   rd_rsp_data;
  logic          rd_rsp_last;
  logic          rd_rsp_err;
  logic [29:0]   dc_rw_addr;
  logic [NW-1:0] dc_wr_en;
  logic [67:0]   dc_wr_data;
  logic [29:0]   dc_rw_tag_addr;
  logic [NW-1:0] lsu_dc_tag_wren;
  logic [NW-1:0] dc_tag_valid;
  logic          crit_valid;
  logic [31:0]   crit_data;
  logic          fill_done;
  logic          fill_err;
  logic          busy;

  lsu_dc_fill_ctl #(.NUM_WAYS(NW), .LINE_BEATS(LB)) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr), .miss_way(miss_way),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .rd_rsp_last(rd_rsp_last),
    .rd_rsp_err(rd_rsp_err),
    .dc_rw_addr(dc_rw_addr), .dc_wr_en(dc_wr_en), .dc_wr_data(dc_wr_data),
    .dc_rw_tag_addr(dc_rw_tag_addr), .lsu_dc_tag_wren(lsu_dc_tag_wren), .dc_tag_valid(dc_tag_valid),
    .crit_valid(crit_valid), .crit_data(crit_data),
    .fill_done(fill_done), .fill_err(fill_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  int unsigned cyc      = 0;

  // Observed events, stamped with the cycle they were seen in
  int unsigned   wr_cyc[$];
  logic [29:0]   wr_addr[$];
  logic [NW-1:0] wr_en[$];
  logic [67:0]   wr_data[$];
  int unsigned   crit_cyc[$];
  logic [31:0]   crit_dat[$];
  int unsigned   done_cyc[$];
  int unsigned   err_cyc[$];
  int unsigned   tag_cyc[$];
  logic [29:0]   tag_addr_seen;
  logic [NW-1:0] tag_wren_seen;
  logic [NW-1:0] tag_valid_seen;
  logic          rdy_at[int unsigned];

  logic          s_ready;
  logic          s_busy;
  logic          s_req_valid;
  logic [31:0]   s_req_addr;
  logic          s_any_out;
  logic          s_any_but_ready;

  task automatic check_eq(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    wr_cyc.delete(); wr_addr.delete(); wr_en.delete(); wr_data.delete();
    crit_cyc.delete(); crit_dat.delete();
    done_cyc.delete(); err_cyc.delete(); tag_cyc.delete();
    rdy_at.delete();
  endtask

  // One clock cycle: inputs already set, sample at negedge, advance past posedge.
  task automatic step();
    @(negedge clk);
    s_ready         = miss_ready;
    s_busy          = busy;
    s_req_valid     = rd_req_valid;
    s_req_addr      = rd_req_addr;
    s_any_but_ready = |{rd_req_valid, rd_req_addr, dc_rw_addr, dc_wr_en, dc_wr_data,
                        dc_rw_tag_addr, lsu_dc_tag_wren, dc_tag_valid, crit_valid,
                        crit_data, fill_done, fill_err, busy};
    s_any_out       = s_any_but_ready | miss_ready;
    rdy_at[cyc]     = miss_ready;
    if (dc_wr_en != '0) begin
      wr_cyc.push_back(cyc); wr_addr.push_back(dc_rw_addr);
      wr_en.push_back(dc_wr_en); wr_data.push_back(dc_wr_data);
    end
    if (crit_valid) begin
      crit_cyc.push_back(cyc); crit_dat.push_back(crit_data);
    end
    if (fill_done) done_cyc.push_back(cyc);
    if (fill_err) err_cyc.push_back(cyc);
    if (lsu_dc_tag_wren != '0) begin
      tag_cyc.push_back(cyc);
      tag_addr_seen  = dc_rw_tag_addr;
      tag_wren_seen  = lsu_dc_tag_wren;
      tag_valid_seen = dc_tag_valid;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Parity-extended data word, parity computed by bit counting
  function automatic logic [67:0] exp_word(input logic [63:0] d);
    logic [67:0] r;
    r[31:0]  = d[31:0];
    r[32]    = ($countones(d[15:0])  % 2) != 0;
    r[33]    = ($countones(d[31:16]) % 2) != 0;
    r[65:34] = d[63:32];
    r[66]    = ($countones(d[47:32]) % 2) != 0;
    r[67]    = ($countones(d[63:48]) % 2) != 0;
    return r;
  endfunction

  // Position within the line of the i-th returned beat
  function automatic int unsigned seq_pos(input logic [31:0] ba, input int unsigned i);
`ifdef RV_DC_FILL_WRAP_EN
    return ((ba / 8) % LB + i) % LB;
`else
    return i + 0 * ba;
`endif
  endfunction

  function automatic logic [31:0] req_byte(input logic [31:0] ba);
`ifdef RV_DC_FILL_WRAP_EN
    return ba - (ba % 8);
`else
    return ba - (ba % LINE_BYTES);
`endif
  endfunction

  task automatic do_fill(input logic [29:0] a, input logic [NW-1:0] way, input int unsigned stall,
                         input int unsigned gmin, input int unsigned gmax, input int unsigned err_beat,
                         input int unsigned last_beat, input logic [63:0] beat0, output int unsigned b0);
    logic [63:0] bd[LB];
    int unsigned bc[LB];
    logic [31:0] ba, base;
    int unsigned crit, kc, L, gap;
    bit          exp_err;
    ba   = {a, 2'b00};
    base = ba - (ba % LINE_BYTES);
    crit = (ba / 8) % LB;
    kc   = 0;
    clear_obs();

    miss_valid   = 1'b0;
    rd_rsp_valid = 1'($urandom_range(0, 1));
    rd_rsp_data  = {$urandom, $urandom};
    rd_rsp_err   = 1'($urandom_range(0, 1));
    step();
    check_eq("idle_ready", 68'(s_ready), 68'(1));
    check_eq("idle_busy", 68'(s_busy), 68'(0));

    miss_valid = 1'b1; miss_addr = a; miss_way = way; rd_rsp_valid = 1'b0;
    step();
    check_eq("accept_ready", 68'(s_ready), 68'(1));
    miss_addr  = 30'($urandom);
    miss_way   = NW'($urandom);
    miss_valid = 1'($urandom_range(0, 1));

    for (int unsigned s = 0; s <= stall; s++) begin
      rd_req_ready = (s == stall);
      rd_rsp_valid = 1'($urandom_range(0, 1));
      rd_rsp_data  = {$urandom, $urandom};
      rd_rsp_err   = 1'($urandom_range(0, 1));
      rd_rsp_last  = 1'($urandom_range(0, 1));
      step();
      check_eq("req_valid", 68'(s_req_valid), 68'(1));
      check_eq("req_addr", 68'(s_req_addr), 68'(req_byte(ba)));
      check_eq("req_busy_ready", 68'(s_ready), 68'(0));
    end
    rd_req_ready = 1'b0;

    for (int unsigned i = 0; i < LB; i++) begin
      gap = $urandom_range(gmin, gmax);
      for (int unsigned g = 0; g < gap; g++) begin
        rd_rsp_valid = 1'b0;
        rd_rsp_err   = 1'($urandom_range(0, 1));
        rd_rsp_last  = 1'($urandom_range(0, 1));
        step();
      end
      bd[i]        = (i == 0) ? beat0 : {$urandom, $urandom};
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = bd[i];
      rd_rsp_last  = (i == last_beat);
      rd_rsp_err   = (i == err_beat);
      bc[i]        = cyc;
      if (seq_pos(ba, i) == crit) kc = i;
      step();
      if (i == 0) check_eq("req_dropped", 68'(s_req_valid), 68'(0));
    end

    miss_valid  = 1'b0;
    rd_rsp_last = 1'b0;
    rd_rsp_err  = 1'b0;
    for (int unsigned p = 0; p < 4; p++) begin
      rd_rsp_valid = 1'($urandom_range(0, 1));
      rd_rsp_data  = {$urandom, $urandom};
      step();
    end
    rd_rsp_valid = 1'b0;

    L       = bc[LB-1];
    exp_err = (err_beat < LB) || (last_beat != LB - 1);
    check_eq("wr_count", 68'(wr_cyc.size()), 68'(LB));
    for (int unsigned i = 0; i < LB; i++) begin
      if (i < wr_cyc.size()) begin
        check_eq("wr_cyc", 68'(wr_cyc[i]), 68'(bc[i] + 1));
        check_eq("wr_addr", 68'({wr_addr[i], 2'b00}), 68'(base + 32'(8 * seq_pos(ba, i))));
        check_eq("wr_en", 68'(wr_en[i]), 68'(way));
        check_eq("wr_data", wr_data[i], exp_word(bd[i]));
      end
    end
    check_eq("crit_count", 68'(crit_cyc.size()), 68'(1));
    if (crit_cyc.size() > 0) begin
      check_eq("crit_cyc", 68'(crit_cyc[0]), 68'(bc[kc] + 1));
      check_eq("crit_data", 68'(crit_dat[0]), 68'(ba[2] ? bd[kc][63:32] : bd[kc][31:0]));
    end
    if (exp_err) begin
      check_eq("err_count", 68'(err_cyc.size()), 68'(1));
      if (err_cyc.size() > 0) check_eq("err_cyc", 68'(err_cyc[0]), 68'(L + 1));
      check_eq("err_no_done", 68'(done_cyc.size()), 68'(0));
      check_eq("err_no_tag", 68'(tag_cyc.size()), 68'(0));
      check_eq("err_busy_ready", 68'(rdy_at[L+1]), 68'(0));
      check_eq("err_ready_back", 68'(rdy_at[L+2]), 68'(1));
    end else begin
      check_eq("done_count", 68'(done_cyc.size()), 68'(1));
      if (done_cyc.size() > 0) check_eq("done_cyc", 68'(done_cyc[0]), 68'(L + 2));
      check_eq("ok_no_err", 68'(err_cyc.size()), 68'(0));
      check_eq("tag_count", 68'(tag_cyc.size()), 68'(1));
      if (tag_cyc.size() > 0) begin
        check_eq("tag_cyc", 68'(tag_cyc[0]), 68'(L + 2));
        check_eq("tag_addr", 68'({tag_addr_seen, 2'b00}), 68'(base));
        check_eq("tag_wren", 68'(tag_wren_seen), 68'(way));
        check_eq("tag_valid", 68'(tag_valid_seen), 68'(way));
      end
      check_eq("ok_busy_ready", 68'(rdy_at[L+2]), 68'(0));
      check_eq("ok_ready_back", 68'(rdy_at[L+3]), 68'(1));
    end
    b0 = bc[0];
  endtask

  initial begin
    int unsigned   b0;
    logic [31:0]   first_wr;
    logic [NW-1:0] w;
    int unsigned   eb, lb;

    rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; miss_way = '0;
    rd_req_ready = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_data = '0;
    rd_rsp_last = 1'b0; rd_rsp_err = 1'b0;
    for (int unsigned r = 0; r < 3; r++) begin
      miss_valid = 1'b1;
      step();
      check_eq("reset_outputs", 68'(s_any_out), 68'(0));
    end
    miss_valid = 1'b0;
    rst = 1'b0;
    step();
    check_eq("release_ready", 68'(s_ready), 68'(1));
    check_eq("release_busy", 68'(s_busy), 68'(0));

    // Miss at byte 0x1234, way 0010, back-to-back beats
    do_fill(30'(32'h1234 >> 2), 4'b0010, 0, 0, 0, LB, LB - 1, 64'h00000001_00000003, b0);
`ifdef RV_DC_FILL_WRAP_EN
    first_wr = 32'h1230;
`else
    first_wr = 32'h1220;
`endif
    if (wr_addr.size() > 0) begin
      check_eq("t1_first_addr", 68'({wr_addr[0], 2'b00}), 68'(first_wr));
      check_eq("t1_first_data", wr_data[0], 68'h4_0000_0004_0000_0003);
    end
    check_eq("t1_tag_addr", 68'({tag_addr_seen, 2'b00}), 68'(32'h1220));
    if (done_cyc.size() > 0) check_eq("t1_done_lat", 68'(done_cyc[0]), 68'(b0 + 5));

    // Same miss, bus error on beat 1
    do_fill(30'(32'h1234 >> 2), 4'b0010, 0, 0, 0, 1, LB - 1, {$urandom, $urandom}, b0);
    if (err_cyc.size() > 0) check_eq("t2_err_lat", 68'(err_cyc[0]), 68'(b0 + 4));
    check_eq("t2_ready_lat", 68'(rdy_at[b0+5]), 68'(1));

    // Request held off for five cycles
    do_fill(30'(32'h1234 >> 2), 4'b0100, 5, 0, 0, LB, LB - 1, {$urandom, $urandom}, b0);

    // Two-cycle gaps, last flag on beat 2
    do_fill(30'(32'h1234 >> 2), 4'b1000, 0, 2, 2, LB, 2, {$urandom, $urandom}, b0);

    // Reset after two beats of a fill
    miss_valid = 1'b1; miss_addr = 30'(32'h1234 >> 2); miss_way = 4'b0001;
    step();
    miss_valid = 1'b0; rd_req_ready = 1'b1;
    step();
    rd_req_ready = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      rd_rsp_valid = 1'b1; rd_rsp_data = {$urandom, $urandom}; rd_rsp_last = 1'b0;
      step();
    end
    rd_rsp_valid = 1'b0;
    clear_obs();
    rst = 1'b1;
    step();
    check_eq("midfill_rst_outputs", 68'(s_any_out), 68'(0));
    rst = 1'b0;
    step();
    check_eq("post_rst_quiet", 68'(s_any_but_ready), 68'(0));
    check_eq("post_rst_ready", 68'(s_ready), 68'(1));
    for (int unsigned i = 0; i < 2; i++) begin
      rd_rsp_valid = 1'b1; rd_rsp_data = {$urandom, $urandom}; rd_rsp_last = (i == 1);
      step();
    end
    rd_rsp_valid = 1'b0; rd_rsp_last = 1'b0;
    step();
    check_eq("stray_no_write", 68'(wr_cyc.size()), 68'(0));
    check_eq("stray_no_pulse", 68'(done_cyc.size() + err_cyc.size() + tag_cyc.size()), 68'(0));
    do_fill(30'(32'h2000 >> 2), 4'b0010, 0, 0, 0, LB, LB - 1, {$urandom, $urandom}, b0);

    // Randomized fills
    for (int unsigned t = 0; t < 40; t++) begin
      w  = NW'(1) << $urandom_range(0, NW - 1);
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, LB - 1) : LB;
      lb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, LB) : LB - 1;
      do_fill(30'($urandom), w, $urandom_range(0, 3), 0, 2, eb, lb, {$urandom, $urandom}, b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
